// File: rtl/avalon_rr_arbiter_if.sv
// Signal bundle for the round-robin arbiter: N host-side Avalon-MM ports (flattened,
// host i at slice i), the shared bus-side port, and the grant/timeout status outputs.
interface avalon_rr_arbiter_if #(
  parameter int N_HOSTS = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
);
  localparam int BE_W = DATA_W / 8;

  logic [N_HOSTS*ADDR_W-1:0] h_address;
  logic [N_HOSTS*BE_W-1:0]   h_byteenable;
  logic [N_HOSTS*DATA_W-1:0] h_writedata;
  logic [N_HOSTS-1:0]        h_read;
  logic [N_HOSTS-1:0]        h_write;
  logic [N_HOSTS-1:0]        h_waitrequest;
  logic [N_HOSTS*DATA_W-1:0] h_readdata;
  logic [N_HOSTS-1:0]        h_readdatavalid;

  logic [ADDR_W-1:0]         m_address;
  logic [BE_W-1:0]           m_byteenable;
  logic [DATA_W-1:0]         m_writedata;
  logic                      m_read;
  logic                      m_write;
  logic                      m_waitrequest;
  logic [DATA_W-1:0]         m_readdata;
  logic                      m_readdatavalid;

  logic [N_HOSTS-1:0]        grant;
  logic                      timeout_err;

  // Arbiter view.
  modport slave (
    input  h_address, h_byteenable, h_writedata, h_read, h_write,
    output h_waitrequest, h_readdata, h_readdatavalid,
    output m_address, m_byteenable, m_writedata, m_read, m_write,
    input  m_waitrequest, m_readdata, m_readdatavalid,
    output grant, timeout_err
  );

  // Environment view: hosts plus the downstream agent.
  modport master (
    output h_address, h_byteenable, h_writedata, h_read, h_write,
    input  h_waitrequest, h_readdata, h_readdatavalid,
    input  m_address, m_byteenable, m_writedata, m_read, m_write,
    output m_waitrequest, m_readdata, m_readdatavalid,
    input  grant, timeout_err
  );
endinterface

// File: rtl/avalon_rr_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM agent port among N_HOSTS hosts. The grant is
// held for one whole transaction; read-data waits are bounded by TIMEOUT cycles.
module avalon_rr_arbiter #(
  parameter int N_HOSTS = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input logic                clk,
  input logic                reset,
  avalon_rr_arbiter_if.slave bus
);
  localparam int BE_W  = DATA_W / 8;
  localparam int PTR_W = $clog2(N_HOSTS);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    RDWAIT
  } state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [N_HOSTS-1:0] req;
  logic [PTR_W-1:0]   next_owner;
  logic               scan_found;
  int                 scan_idx;
  logic               own_req, own_rd, own_wr;

  logic [ADDR_W-1:0]  addr_a  [N_HOSTS];
  logic [BE_W-1:0]    be_a    [N_HOSTS];
  logic [DATA_W-1:0]  wdata_a [N_HOSTS];
  logic [DATA_W-1:0]  rdata_a [N_HOSTS];

  for (genvar i = 0; i < N_HOSTS; i++) begin : g_host
    assign addr_a[i]  = bus.h_address[i*ADDR_W +: ADDR_W];
    assign be_a[i]    = bus.h_byteenable[i*BE_W +: BE_W];
    assign wdata_a[i] = bus.h_writedata[i*DATA_W +: DATA_W];
    assign bus.h_readdata[i*DATA_W +: DATA_W] = rdata_a[i];
  end

  // A simultaneous read+write counts as a write; the read is masked towards the bus.
  assign req     = bus.h_read | bus.h_write;
  assign own_req = req[owner_q];
  assign own_wr  = bus.h_write[owner_q];
  assign own_rd  = bus.h_read[owner_q] & ~bus.h_write[owner_q];

  // First requester after the last-served host, wrapping explicitly for any N.
  always_comb begin
    next_owner = ptr_q;
    scan_found = 1'b0;
    scan_idx   = 0;
    for (int k = 1; k <= N_HOSTS; k++) begin
      scan_idx = int'(ptr_q) + k;
      if (scan_idx >= N_HOSTS) scan_idx = scan_idx - N_HOSTS;
      if (!scan_found && req[PTR_W'(scan_idx)]) begin
        scan_found = 1'b1;
        next_owner = PTR_W'(scan_idx);
      end
    end
  end

  // NOTE: every output and next-state variable gets a default before the case so no
  // path through this block can leave one unassigned and infer a latch.
  always_comb begin
    state_d             = state_q;
    owner_d             = owner_q;
    ptr_d               = ptr_q;
    cnt_d               = cnt_q;
    bus.m_address       = '0;
    bus.m_byteenable    = '0;
    bus.m_writedata     = '0;
    bus.m_read          = 1'b0;
    bus.m_write         = 1'b0;
    bus.h_waitrequest   = req;
    bus.h_readdatavalid = '0;
    bus.grant           = '0;
    bus.timeout_err     = 1'b0;
    for (int i = 0; i < N_HOSTS; i++) rdata_a[i] = '0;

    unique case (state_q)
      IDLE: begin
        if (scan_found) begin
          owner_d = next_owner;
          ptr_d   = next_owner;
          state_d = CMD;
        end
      end

      CMD: begin
        bus.grant[owner_q]         = 1'b1;
        bus.m_address              = addr_a[owner_q];
        bus.m_byteenable           = be_a[owner_q];
        bus.m_writedata            = wdata_a[owner_q];
        bus.m_write                = own_wr;
        bus.m_read                 = own_rd;
        bus.h_waitrequest[owner_q] = bus.m_waitrequest;
        if (!own_req) begin
          state_d = IDLE;
        end else if (!bus.m_waitrequest) begin
          if (own_wr) begin
            state_d = IDLE;
          end else if (bus.m_readdatavalid) begin
            bus.h_readdatavalid[owner_q] = 1'b1;
            rdata_a[owner_q]             = bus.m_readdata;
            state_d                      = IDLE;
          end else begin
            cnt_d   = '0;
            state_d = RDWAIT;
          end
        end
      end

      RDWAIT: begin
        bus.grant[owner_q] = 1'b1;
        if (bus.m_readdatavalid) begin
          bus.h_readdatavalid[owner_q] = 1'b1;
          rdata_a[owner_q]             = bus.m_readdata;
          cnt_d                        = '0;
          state_d                      = IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          // Dead agent: complete the read with zero data so the owner is released.
          bus.h_readdatavalid[owner_q] = 1'b1;
          bus.timeout_err              = 1'b1;
          cnt_d                        = '0;
          state_d                      = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge value of every other flop regardless of evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= PTR_W'(N_HOSTS - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule
